dff_response_checker: RTL

- Synthesizable self-checking monitor for the three-variant D flip-flop block (non-resettable, synchronous-reset, asynchronous-reset outputs).
- Where a bench drives stimulus into the flop, this block sits at the output end. It observes the flop's data input, reset, and three outputs.
- It keeps a cycle-accurate golden model, flags mismatches per variant, and keeps counters and first-failure capture, so benches and FPGA builds report pass/fail in hardware.

---
 rtl/dff_response_checker_if.sv | 39 +++
 rtl/dff_response_checker.sv | 93 +++++++++
 2 files changed

// File: rtl/dff_response_checker_if.sv
// Observation/result bundle for dff_response_checker: flop-side samples in,
// sticky flags, counters and first-failure capture out.
`timescale 1ns/1ps
interface dff_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             check_en_i;
  logic             clear_i;
  logic             d_i;
  logic             dut_reset_i;
  logic             q_norst_i;
  logic             q_syncrst_i;
  logic             q_asyncrst_i;
  logic             err_norst_o;
  logic             err_syncrst_o;
  logic             err_asyncrst_o;
  logic [CNT_W-1:0] err_count_o;
  logic [CNT_W-1:0] check_count_o;
  logic             first_err_vld_o;
  logic [CNT_W-1:0] first_err_cycle_o;
  logic [2:0]       first_err_mask_o;
  logic             pass_o;

  modport master (
    output check_en_i, clear_i, d_i, dut_reset_i,
           q_norst_i, q_syncrst_i, q_asyncrst_i,
    input  err_norst_o, err_syncrst_o, err_asyncrst_o,
           err_count_o, check_count_o,
           first_err_vld_o, first_err_cycle_o, first_err_mask_o, pass_o
  );

  modport slave (
    input  check_en_i, clear_i, d_i, dut_reset_i,
           q_norst_i, q_syncrst_i, q_asyncrst_i,
    output err_norst_o, err_syncrst_o, err_asyncrst_o,
           err_count_o, check_count_o,
           first_err_vld_o, first_err_cycle_o, first_err_mask_o, pass_o
  );
endinterface

// File: rtl/dff_response_checker.sv
// Golden-model monitor for the three-variant D flop (norst/syncrst/asyncrst):
// sticky per-variant error flags, saturating counters, first-failure capture.
`timescale 1ns/1ps
module dff_response_checker #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  dff_response_checker_if.slave  chk
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             exp_n, exp_s, exp_a;
  logic             vld_n, vld_s, vld_a;
  logic             exp_a_eff, vld_a_eff;
  logic [2:0]       mis;
  logic             any_mis;

  logic [2:0]       err_q;
  logic [CNT_W-1:0] err_cnt, chk_cnt, first_cycle;
  logic             first_vld;
  logic [2:0]       first_mask;

  // The async flop clears as soon as its reset rises, so a reset seen
  // before this edge overrides the registered expectation.
  always_comb begin
    exp_a_eff = chk.dut_reset_i ? 1'b0 : exp_a;
    vld_a_eff = chk.dut_reset_i | vld_a;
    mis[0]    = vld_n & (chk.q_norst_i    != exp_n);
    mis[1]    = vld_s & (chk.q_syncrst_i  != exp_s);
    mis[2]    = vld_a_eff & (chk.q_asyncrst_i != exp_a_eff);
    any_mis   = chk.check_en_i & (|mis);
  end

  // Reference flops track the DUT regardless of check_en_i / clear_i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_n <= 1'b0;
      exp_s <= 1'b0;
      exp_a <= 1'b0;
      vld_n <= 1'b0;
      vld_s <= 1'b0;
      vld_a <= 1'b0;
    end else begin
      exp_n <= chk.d_i;
      exp_s <= chk.dut_reset_i ? 1'b0 : chk.d_i;
      exp_a <= chk.dut_reset_i ? 1'b0 : chk.d_i;
      vld_n <= 1'b1;
      vld_s <= 1'b1;
      vld_a <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q       <= '0;
      err_cnt     <= '0;
      chk_cnt     <= '0;
      first_vld   <= 1'b0;
      first_cycle <= '0;
      first_mask  <= '0;
    end else if (chk.clear_i) begin
      err_q       <= '0;
      err_cnt     <= '0;
      chk_cnt     <= '0;
      first_vld   <= 1'b0;
      first_cycle <= '0;
      first_mask  <= '0;
    end else if (chk.check_en_i) begin
      if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 1'b1;
      if (any_mis) begin
        err_q <= err_q | mis;
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        // Cycle index is the count before this edge's increment.
        if (!first_vld) begin
          first_vld   <= 1'b1;
          first_cycle <= chk_cnt;
          first_mask  <= mis;
        end
      end
    end
  end

  assign chk.err_norst_o       = err_q[0];
  assign chk.err_syncrst_o     = err_q[1];
  assign chk.err_asyncrst_o    = err_q[2];
  assign chk.err_count_o       = err_cnt;
  assign chk.check_count_o     = chk_cnt;
  assign chk.first_err_vld_o   = first_vld;
  assign chk.first_err_cycle_o = first_cycle;
  assign chk.first_err_mask_o  = first_mask;
  assign chk.pass_o            = (chk_cnt != '0) && (err_cnt == '0);
endmodule
